activation_controller: RTL

//  Sequences a job of row vectors from the systolic-array accumulator through the activation stage.

---
 rtl/activation_pkg.sv | 17 +
 rtl/activation_controller_relu_lanes.sv | 14 +
 rtl/activation_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/activation_pkg.sv
// Shared types for the activation controller: activation select and sequencer states.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS  = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_SIGMOID = 2'b10
  } act_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } act_state_e;

endpackage

// File: rtl/activation_controller_relu_lanes.sv
// Combinational per-lane ReLU: negative lanes clamp to zero, width unchanged.
module relu_lanes #(
  parameter int DATA_WIDTH = 8,
  parameter int SA_LENGTH  = 256
) (
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] i_data,
  output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] o_data
);

  for (genvar g = 0; g < SA_LENGTH; g++) begin : g_lane
    assign o_data[g] = i_data[g][DATA_WIDTH-1] ? '0 : i_data[g];
  end

endmodule

// File: rtl/activation_controller.sv
// Job sequencer: one stage register plus an output register between the accumulator
// stream and the output buffer, applying bypass/ReLU/external Sigmoid per latched select.
module activation_controller
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SA_LENGTH     = 256,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic [ROW_CNT_WIDTH-1:0]             i_num_rows,
  input  logic [1:0]                           i_act_sel,
  output logic                                 o_busy,
  output logic                                 o_done,
  input  logic                                 i_in_valid,
  output logic                                 o_in_ready,
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] i_in_data,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] o_out_data,
  output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] o_act_in,
  output logic                                 o_act_en,
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] i_act_out
);

  act_state_e                           r_state;
  logic                                 r_busy;
  logic                                 r_done;
  logic [ROW_CNT_WIDTH-1:0]             r_num_rows;
  logic [1:0]                           r_sel;
  logic [ROW_CNT_WIDTH-1:0]             r_in_cnt;
  logic [ROW_CNT_WIDTH-1:0]             r_out_cnt;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] r_s1;
  logic                                 r_s1_valid;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] r_out_data;
  logic                                 r_out_valid;

  logic                                 w_adv;
  logic                                 w_in_ready;
  logic                                 w_in_hs;
  logic                                 w_out_hs;
  logic                                 w_job_start;
  logic                                 w_sig_en;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] w_relu;
  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] w_f;

  assign w_adv       = r_s1_valid && (!r_out_valid || i_out_ready);
  assign w_in_ready  = (r_state == RUN) && (r_in_cnt < r_num_rows) && (!r_s1_valid || w_adv);
  assign w_in_hs     = i_in_valid && w_in_ready;
  assign w_out_hs    = r_out_valid && i_out_ready;
  assign w_job_start = (r_state == IDLE) && i_start;

  // The shared Sigmoid only sees data while it is actually selected and loaded.
  assign w_sig_en = r_s1_valid && (r_sel == ACT_SIGMOID);
  assign o_act_en = w_sig_en;
  assign o_act_in = w_sig_en ? r_s1 : '0;

  relu_lanes #(
    .DATA_WIDTH (DATA_WIDTH),
    .SA_LENGTH  (SA_LENGTH)
  ) u_relu (
    .i_data (r_s1),
    .o_data (w_relu)
  );

  // Reserved select 2'b11 falls through to bypass.
  always_comb begin
    w_f = r_s1;
    if (r_sel == ACT_RELU) begin
      w_f = w_relu;
    end else if (r_sel == ACT_SIGMOID) begin
      w_f = i_act_out;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1        <= '0;
      r_s1_valid  <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
    end else begin
      if (w_in_hs) begin
        r_s1       <= i_in_data;
        r_s1_valid <= 1'b1;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv) begin
        r_out_data  <= w_f;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      if (w_job_start) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_hs)  r_in_cnt  <= r_in_cnt + 1'b1;
        if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_num_rows <= '0;
      r_sel      <= ACT_BYPASS;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_num_rows != '0) begin
              r_state    <= RUN;
              r_busy     <= 1'b1;
              r_num_rows <= i_num_rows;
              r_sel      <= i_act_sel;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_in_hs && (r_in_cnt == r_num_rows - 1'b1)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_hs && (r_out_cnt == r_num_rows - 1'b1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule
